// File: rtl/order_manager_if.sv
// Game-side bus of order_manager: phase/serve inputs and the score/order status outputs.
interface order_manager_if;
  logic [2:0]      game_state;
  logic            order_served;
  logic [7:0]      time_left;
  logic [9:0]      point_total;
  logic [3:0]      orders;
  logic [3:0][4:0] order_times;
  logic            game_over;

  modport master (
    output game_state, order_served,
    input  time_left, point_total, orders, order_times, game_over
  );

  modport slave (
    input  game_state, order_served,
    output time_left, point_total, orders, order_times, game_over
  );
endinterface

// File: rtl/order_manager.sv
// Round timer, order queue (4 slots, slot 0 oldest) and score keeper for one game round.
// Optional macro ORDER_PENALTY_EN: expired orders cost EXPIRE_POINTS (score floors at 0).
module order_manager #(
  parameter int         CYCLES_PER_SEC = 65000000,
  parameter int         GAME_SECONDS   = 120,
  parameter int         ORDER_SECONDS  = 30,
  parameter int         ORDER_INTERVAL = 20,
  parameter int         SERVE_POINTS   = 20,
  parameter int         EXPIRE_POINTS  = 10,
  parameter logic [2:0] PLAY_STATE     = 3'd1
) (
  input  logic                  clock,
  input  logic                  reset,
  order_manager_if.slave        bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW  = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int SPW = (ORDER_INTERVAL > 1) ? $clog2(ORDER_INTERVAL) : 1;
  localparam logic [CW-1:0]  CYC_LAST   = CW'(CYCLES_PER_SEC - 1);
  localparam logic [SPW-1:0] SPAWN_LAST = SPW'(ORDER_INTERVAL - 1);

`ifdef ORDER_PENALTY_EN
  localparam bit PENALTY_EN = 1'b1;
`else
  localparam bit PENALTY_EN = 1'b0;
`endif

  logic [1:0]      state_q, state_d;
  logic [7:0]      time_left_q, time_left_d;
  logic [9:0]      point_total_q, point_total_d;
  logic [3:0]      orders_q, orders_d;
  logic [3:0][4:0] order_times_q, order_times_d;
  logic            game_over_q, game_over_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [SPW-1:0]  spawn_q, spawn_d;
  logic            tick;

  // Drop slot 0 and move every younger order one slot toward the front.
  function automatic logic [3:0][4:0] pop_front(input logic [3:0][4:0] s);
    return {5'd0, s[3], s[2], s[1]};
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
    state_d       = state_q;
    time_left_d   = time_left_q;
    point_total_d = point_total_q;
    orders_d      = orders_q;
    order_times_d = order_times_q;
    game_over_d   = 1'b0;
    cyc_d         = cyc_q;
    spawn_d       = spawn_q;
    tick          = 1'b0;

    // NOTE: blocking assignments here are intentional; each step below sees the result of the one before.
    case (state_q)
      ST_IDLE: begin
        if (bus.game_state == PLAY_STATE) begin
          state_d          = ST_RUN;
          time_left_d      = 8'(GAME_SECONDS);
          point_total_d    = '0;
          orders_d         = 4'd1;
          order_times_d    = '0;
          order_times_d[0] = 5'(ORDER_SECONDS);
          cyc_d            = '0;
          spawn_d          = '0;
        end
      end

      ST_RUN: begin
        if (bus.game_state != PLAY_STATE) begin
          state_d = ST_IDLE;
        end else begin
          tick  = (cyc_q == CYC_LAST);
          cyc_d = tick ? '0 : cyc_q + CW'(1);

          if (bus.order_served && orders_d != 4'd0) begin
            order_times_d = pop_front(order_times_d);
            orders_d      = orders_d - 4'd1;
            if (int'(point_total_d) + SERVE_POINTS > 1023) point_total_d = 10'd1023;
            else                                            point_total_d = point_total_d + 10'(SERVE_POINTS);
          end

          if (tick) begin
            if (orders_d != 4'd0 && order_times_d[0] == 5'd1) begin
              order_times_d = pop_front(order_times_d);
              orders_d      = orders_d - 4'd1;
              if (PENALTY_EN) begin
                if (int'(point_total_d) < EXPIRE_POINTS) point_total_d = '0;
                else                                     point_total_d = point_total_d - 10'(EXPIRE_POINTS);
              end
            end
            for (int i = 0; i < 4; i++) begin
              if (i < int'(orders_d)) order_times_d[i] = order_times_d[i] - 5'd1;
            end

            // Spawn interval keeps running even when the queue is full.
            if (spawn_q == SPAWN_LAST) begin
              spawn_d = '0;
              if (orders_d < 4'd4) begin
                order_times_d[orders_d[1:0]] = 5'(ORDER_SECONDS);
                orders_d                     = orders_d + 4'd1;
              end
            end else begin
              spawn_d = spawn_q + SPW'(1);
            end

            time_left_d = time_left_q - 8'd1;
            if (time_left_q == 8'd1) begin
              state_d       = ST_DONE;
              game_over_d   = 1'b1;
              orders_d      = '0;
              order_times_d = '0;
            end
          end
        end
      end

      ST_DONE: begin
        if (bus.game_state != PLAY_STATE) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      time_left_q   <= '0;
      point_total_q <= '0;
      orders_q      <= '0;
      // NOTE: order_times is a four-entry flop array, not a RAM, so it is cleared with the rest.
      order_times_q <= '0;
      game_over_q   <= 1'b0;
      cyc_q         <= '0;
      spawn_q       <= '0;
    end else begin
      state_q       <= state_d;
      time_left_q   <= time_left_d;
      point_total_q <= point_total_d;
      orders_q      <= orders_d;
      order_times_q <= order_times_d;
      game_over_q   <= game_over_d;
      cyc_q         <= cyc_d;
      spawn_q       <= spawn_d;
    end
  end

  assign bus.time_left   = time_left_q;
  assign bus.point_total = point_total_q;
  assign bus.orders      = orders_q;
  assign bus.order_times = order_times_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_order_manager.sv
// Directed bench for order_manager: a per-row vector table on a small-timing instance,
// plus a hand sequence on a second instance for queue-full, score saturation and reset.
module tb_order_manager;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

`ifdef ORDER_PENALTY_EN
  localparam int PEN = 10;
`else
  localparam int PEN = 0;
`endif

  order_manager_if ifa ();
  order_manager_if ifb ();

  order_manager #(
    .CYCLES_PER_SEC(4), .GAME_SECONDS(10), .ORDER_SECONDS(3), .ORDER_INTERVAL(2)
  ) dut_a (.clock(clk), .reset(rst_a), .bus(ifa));

  order_manager #(
    .CYCLES_PER_SEC(2), .GAME_SECONDS(10), .ORDER_SECONDS(20), .ORDER_INTERVAL(1),
    .SERVE_POINTS(500)
  ) dut_b (.clock(clk), .reset(rst_b), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int s3, input int s2, input int s1, input int s0);
    return 32'((s3 << 15) | (s2 << 10) | (s1 << 5) | s0);
  endfunction

  typedef struct {
    logic       rst;
    logic [2:0] gs;
    logic       sv;
    int         n;
    int         tl;
    int         pts;
    int         ord;
    int         s0;
    int         s1;
    logic       go;
  } vec_t;

  vec_t vecs [26];

  task automatic step_b(input logic rst, input logic [2:0] gs, input logic sv, input int n);
    rst_b = rst;
    ifb.game_state   = gs;
    ifb.order_served = sv;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.game_state = 3'd0; ifa.order_served = 1'b0;
    ifb.game_state = 3'd0; ifb.order_served = 1'b0;

    // rst gs sv n | time_left points orders slot0 slot1 game_over
    vecs[0]  = '{1'b1, 3'd0, 1'b0, 1,  0, 0,          0, 0, 0, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 1'b0, 1, 10, 0,          1, 3, 0, 1'b0};
    vecs[2]  = '{1'b0, 3'd1, 1'b1, 1, 10, 20,         0, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 3'd1, 1'b1, 1, 10, 20,         0, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 1'b0, 2,  9, 20,         0, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 1'b0, 4,  8, 20,         1, 3, 0, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 1'b0, 4,  7, 20,         1, 2, 0, 1'b0};
    vecs[7]  = '{1'b0, 3'd1, 1'b0, 4,  6, 20,         2, 1, 3, 1'b0};
    vecs[8]  = '{1'b0, 3'd1, 1'b0, 3,  6, 20,         2, 1, 3, 1'b0};
    vecs[9]  = '{1'b0, 3'd1, 1'b1, 1,  5, 40,         1, 2, 0, 1'b0};
    vecs[10] = '{1'b0, 3'd1, 1'b0, 4,  4, 40,         2, 1, 3, 1'b0};
    vecs[11] = '{1'b0, 3'd1, 1'b0, 4,  3, 40 - PEN,   1, 2, 0, 1'b0};
    vecs[12] = '{1'b0, 3'd1, 1'b0, 4,  2, 40 - PEN,   2, 1, 3, 1'b0};
    vecs[13] = '{1'b0, 3'd1, 1'b0, 4,  1, 40 - 2*PEN, 1, 2, 0, 1'b0};
    vecs[14] = '{1'b0, 3'd1, 1'b0, 3,  1, 40 - 2*PEN, 1, 2, 0, 1'b0};
    vecs[15] = '{1'b0, 3'd1, 1'b0, 1,  0, 40 - 2*PEN, 0, 0, 0, 1'b1};
    vecs[16] = '{1'b0, 3'd1, 1'b0, 1,  0, 40 - 2*PEN, 0, 0, 0, 1'b0};
    vecs[17] = '{1'b0, 3'd1, 1'b1, 1,  0, 40 - 2*PEN, 0, 0, 0, 1'b0};
    vecs[18] = '{1'b0, 3'd0, 1'b0, 1,  0, 40 - 2*PEN, 0, 0, 0, 1'b0};
    vecs[19] = '{1'b0, 3'd1, 1'b0, 1, 10, 0,          1, 3, 0, 1'b0};
    vecs[20] = '{1'b0, 3'd1, 1'b0, 12, 7, 0,          1, 2, 0, 1'b0};
    vecs[21] = '{1'b0, 3'd0, 1'b0, 1,  7, 0,          1, 2, 0, 1'b0};
    vecs[22] = '{1'b0, 3'd0, 1'b1, 1,  7, 0,          1, 2, 0, 1'b0};
    vecs[23] = '{1'b0, 3'd0, 1'b0, 5,  7, 0,          1, 2, 0, 1'b0};
    vecs[24] = '{1'b0, 3'd1, 1'b0, 1, 10, 0,          1, 3, 0, 1'b0};
    vecs[25] = '{1'b1, 3'd1, 1'b1, 1,  0, 0,          0, 0, 0, 1'b0};

    for (int v = 0; v < 26; v++) begin
      rst_a            = vecs[v].rst;
      ifa.game_state   = vecs[v].gs;
      ifa.order_served = vecs[v].sv;
      repeat (vecs[v].n) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("a%0d.time_left", v),   32'(ifa.time_left),   32'(vecs[v].tl));
      check($sformatf("a%0d.point_total", v), 32'(ifa.point_total), 32'(vecs[v].pts));
      check($sformatf("a%0d.orders", v),      32'(ifa.orders),      32'(vecs[v].ord));
      check($sformatf("a%0d.order_times", v), 32'(ifa.order_times), pack4(0, 0, vecs[v].s1, vecs[v].s0));
      check($sformatf("a%0d.game_over", v),   32'(ifa.game_over),   32'(vecs[v].go));
    end

    // Queue fill, dropped spawn when full, serve saturation, reset mid-round with 3 orders.
    step_b(1'b1, 3'd0, 1'b0, 1);
    check("b.reset_orders", 32'(ifb.orders), 32'd0);
    step_b(1'b0, 3'd1, 1'b0, 1);
    check("b.entry_time_left", 32'(ifb.time_left), 32'd10);
    check("b.entry_slots", 32'(ifb.order_times), pack4(0, 0, 0, 20));
    step_b(1'b0, 3'd1, 1'b0, 6);
    check("b.fill_orders", 32'(ifb.orders), 32'd4);
    check("b.fill_slots", 32'(ifb.order_times), pack4(20, 19, 18, 17));
    step_b(1'b0, 3'd1, 1'b0, 2);
    check("b.full_orders", 32'(ifb.orders), 32'd4);
    check("b.full_slots", 32'(ifb.order_times), pack4(19, 18, 17, 16));
    check("b.full_time_left", 32'(ifb.time_left), 32'd6);
    step_b(1'b0, 3'd1, 1'b1, 1);
    check("b.serve1_points", 32'(ifb.point_total), 32'd500);
    check("b.serve1_slots", 32'(ifb.order_times), pack4(0, 19, 18, 17));
    step_b(1'b0, 3'd1, 1'b1, 1);
    check("b.serve2_points", 32'(ifb.point_total), 32'd1000);
    check("b.serve2_slots", 32'(ifb.order_times), pack4(0, 20, 18, 17));
    check("b.serve2_time_left", 32'(ifb.time_left), 32'd5);
    step_b(1'b0, 3'd1, 1'b1, 1);
    check("b.saturate_points", 32'(ifb.point_total), 32'd1023);
    check("b.saturate_orders", 32'(ifb.orders), 32'd2);
    step_b(1'b0, 3'd1, 1'b0, 1);
    check("b.three_orders", 32'(ifb.orders), 32'd3);
    check("b.three_slots", 32'(ifb.order_times), pack4(0, 20, 19, 17));
    step_b(1'b1, 3'd1, 1'b1, 1);
    check("b.midreset_orders", 32'(ifb.orders), 32'd0);
    check("b.midreset_slots", 32'(ifb.order_times), 32'd0);
    check("b.midreset_time_left", 32'(ifb.time_left), 32'd0);
    check("b.midreset_points", 32'(ifb.point_total), 32'd0);
    check("b.midreset_game_over", 32'(ifb.game_over), 32'd0);
    step_b(1'b0, 3'd1, 1'b0, 1);
    check("b.midreset_is_idle", 32'(ifb.time_left), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/order_manager.md
ORDER_MANAGER -- requirements
Module: order_manager

Interface
REQ-001 SHALL have parameter CYCLES_PER_SEC, default 65000000, clock cycles per game second.
REQ-002 SHALL have parameter GAME_SECONDS, default 120, round length in seconds (1..255).
REQ-003 SHALL have parameter ORDER_SECONDS, default 30, lifetime of a new order in seconds (1..31).
REQ-004 SHALL have parameter ORDER_INTERVAL, default 20, seconds between order spawns (>=1).
REQ-005 SHALL have parameter SERVE_POINTS, default 20, points added per served order.
REQ-006 SHALL have parameter EXPIRE_POINTS, default 10, points deducted per expired order.
REQ-007 SHALL have parameter PLAY_STATE, default 3'd1, game_state encoding for active play.
REQ-008 SHALL have ports: clock  input  1  system clock; reset  input  1  synchronous active-high reset.
REQ-009 SHALL have port game_state  input  3  global game phase.
REQ-010 SHALL have port order_served  input  1  one-cycle pulse, a full bowl was delivered.
REQ-011 SHALL have port time_left  output  8  seconds remaining in round.
REQ-012 SHALL have port point_total  output  10  current score.
REQ-013 SHALL have port orders  output  4  number of live orders (0..4).
REQ-014 SHALL have port order_times  output  [3:0][4:0]  seconds remaining per slot; slot 0 oldest; unused slots 0.
REQ-015 SHALL have port game_over  output  1  one-cycle pulse when time_left reaches 0.
REQ-016 Clock is single domain; reset synchronous, active-high; all outputs registered.

Function
REQ-017 States: IDLE, RUNNING, DONE.
REQ-018 IDLE->RUNNING when game_state==PLAY_STATE: time_left=GAME_SECONDS, point_total=0, one order spawned (orders=1, slot0=ORDER_SECONDS), cycle and spawn counters cleared.
REQ-019 RUNNING: a second tick occurs every CYCLES_PER_SEC cycles, first tick CYCLES_PER_SEC cycles after entry.
REQ-020 Per-cycle processing order: serve, then (on tick) expiry/decrement, then spawn, then time_left.
REQ-021 Serve: order_served with orders>0 removes slot 0, shifts slots down, orders-1, adds SERVE_POINTS saturating at 1023; with orders==0 ignored.
REQ-022 Tick expiry: if slot 0 value is 1 it is removed (shift, orders-1) and penalized per REQ-030; all remaining live slots decrement by 1.
REQ-023 Spawn: spawn counter increments each tick; at ORDER_INTERVAL ticks it clears and appends ORDER_SECONDS at slot index orders if orders<4; if full, spawn dropped, counter still clears.
REQ-024 time_left decrements by 1 per tick; on reaching 0: game_over pulses that cycle, state->DONE, orders and order_times cleared, no spawn, point_total held.
REQ-025 RUNNING with game_state!=PLAY_STATE -> IDLE, all outputs hold, game_over not pulsed.
REQ-026 DONE -> IDLE when game_state!=PLAY_STATE; DONE ignores order_served.
REQ-027 IDLE ignores order_served and holds outputs; re-entry per REQ-018 restarts round.

Reset
REQ-028 reset SHALL force state IDLE and time_left=0, point_total=0, orders=0, order_times=0, game_over=0, all counters 0, including mid-round.
REQ-029 reset has priority over every other input in the same cycle.

Configuration
REQ-030 Macro ORDER_PENALTY_EN: defined -> expiry subtracts EXPIRE_POINTS from point_total saturating at 0; undefined -> expiry removes the order with no score change.

Verification (CYCLES_PER_SEC=4, GAME_SECONDS=10, ORDER_SECONDS=3, ORDER_INTERVAL=2)
REQ-031 reset, game_state=1 -> next cycle time_left=10, orders=1, slot0=3, point_total=0.
REQ-032 order_served pulse with 1 order -> point_total=20, orders=0; second pulse with 0 orders -> point_total stays 20.
REQ-033 no serves for 3 s -> slot0 expires, orders drops; with ORDER_PENALTY_EN from score 0 point_total stays 0, from 20 becomes 10.
REQ-034 run 10 s untouched -> spawns at s2,4,6,8 capped at 4 live; at 40 cycles game_over single pulse, time_left=0, orders=0, state DONE.
REQ-035 order_served and tick same cycle with slot0=1 -> served (+20), not penalized, next slot decremented.
REQ-036 reset asserted mid-round with orders=3 -> next cycle all outputs 0, IDLE.
